// File: rtl/ws2812_bit_tx.sv
// WS2812 single-wire NRZ bit encoder: one data bit per bit_rdy_in strobe becomes
// a fixed-period pulse whose high time depends on the bit value.
module ws2812_bit_tx #(
  parameter int CNT_W   = 8,
  parameter int OUT_INV = 0
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             bit_rdy_in,
  input  logic             bit_data_in,
  input  logic [CNT_W-1:0] t0h_cnt_in,
  input  logic [CNT_W-1:0] t1h_cnt_in,
  input  logic [CNT_W-1:0] tp_cnt_in,
  output logic             bit_done_out,
  output logic             busy_out,
  output logic             bit_code_out
);

  localparam logic INV = (OUT_INV != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] th_q, th_d;
  logic [CNT_W-1:0] tp_q, tp_d;
  logic             done_q, done_d;
  logic             code_q, code_d;

  logic             end_of_bit;
  logic             accept;
  logic             line_d;
  logic [CNT_W-1:0] th_sel;
  logic [CNT_W-1:0] th_clamp;
  logic [CNT_W-1:0] tp_clamp;

  // Valid/ready: bit_rdy_in is honoured only in IDLE or in the final cycle of a
  // period (cnt == tp); any other strobe is dropped, nothing is queued.
  always_comb begin
    end_of_bit = (state_q != IDLE) && (cnt_q == tp_q);
    accept     = bit_rdy_in && ((state_q == IDLE) || end_of_bit);
    th_sel     = bit_data_in ? t1h_cnt_in : t0h_cnt_in;
    th_clamp   = (th_sel == '0) ? CNT_W'(1) : th_sel;
    tp_clamp   = (tp_cnt_in < CNT_W'(3)) ? CNT_W'(3) : tp_cnt_in;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    th_d    = th_q;
    tp_d    = tp_q;
    line_d  = code_q ^ INV;
    if (accept) begin
      state_d = HIGH;
      cnt_d   = CNT_W'(1);
      th_d    = th_clamp;
      tp_d    = tp_clamp;
      line_d  = 1'b1;
    end else if (end_of_bit) begin
      state_d = IDLE;
      cnt_d   = '0;
      line_d  = 1'b0;
    end else if (state_q != IDLE) begin
      cnt_d = cnt_q + CNT_W'(1);
      // A high time that reaches the period keeps the line high to the end.
      if ((state_q == HIGH) && (cnt_q == th_q) && (th_q < tp_q)) begin
        state_d = LOW;
        line_d  = 1'b0;
      end
    end
    // Fires one cycle early so the controller's registered strobe meets cnt == tp.
    done_d = (state_d != IDLE) && (cnt_d == (tp_d - CNT_W'(1)));
    code_d = line_d ^ INV;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      th_q    <= '0;
      tp_q    <= '0;
      done_q  <= 1'b0;
      code_q  <= INV;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      th_q    <= th_d;
      tp_q    <= tp_d;
      done_q  <= done_d;
      code_q  <= code_d;
    end
  end

  assign bit_done_out = done_q;
  assign busy_out     = (state_q != IDLE);
  assign bit_code_out = code_q;

endmodule

// File: tb/tb_ws2812_bit_tx.sv
// Directed bench for ws2812_bit_tx: per-cycle samples of both a normal and an
// inverted-output instance are compared against hand-derived waveforms.
module tb_ws2812_bit_tx;

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic       bit_rdy_in;
  logic       bit_data_in;
  logic [7:0] t0h_cnt_in;
  logic [7:0] t1h_cnt_in;
  logic [7:0] tp_cnt_in;
  logic       bit_done_out, busy_out, bit_code_out;
  logic       done_inv, busy_inv, code_inv;

  always #5 clk_in = ~clk_in;

  ws2812_bit_tx #(.CNT_W(8), .OUT_INV(0)) u_dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .bit_rdy_in(bit_rdy_in),
    .bit_data_in(bit_data_in), .t0h_cnt_in(t0h_cnt_in), .t1h_cnt_in(t1h_cnt_in),
    .tp_cnt_in(tp_cnt_in), .bit_done_out(bit_done_out), .busy_out(busy_out),
    .bit_code_out(bit_code_out)
  );

  ws2812_bit_tx #(.CNT_W(8), .OUT_INV(1)) u_dut_inv (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .bit_rdy_in(bit_rdy_in),
    .bit_data_in(bit_data_in), .t0h_cnt_in(t0h_cnt_in), .t1h_cnt_in(t1h_cnt_in),
    .tp_cnt_in(tp_cnt_in), .bit_done_out(done_inv), .busy_out(busy_inv),
    .bit_code_out(code_inv)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Stimulus schedule and per-cycle sample store (sample i taken in cycle i).
  bit         rdy_sched[0:2047];
  int         tp_change_at;
  logic [7:0] tp_new;
  bit         auto_rsp;
  logic       data_fifo[$];
  logic [7:0] exp_q[$];
  logic       s_code[0:2047];
  logic       s_busy[0:2047];
  logic       s_done[0:2047];
  logic       s_inv [0:2047];

  function automatic logic samp(input int sel, input int i);
    case (sel)
      0:       return s_code[i];
      1:       return s_busy[i];
      2:       return s_done[i];
      default: return s_inv[i];
    endcase
  endfunction

  function automatic int count_ones(input int sel, input int from, input int len);
    int n = 0;
    for (int i = from; i < from + len; i++) if (samp(sel, i)) n++;
    return n;
  endfunction

  function automatic int lead_val(input int sel, input int from, input int len, input logic v);
    int n = 0;
    for (int i = from; i < from + len; i++) begin
      if (samp(sel, i) !== v) break;
      n++;
    end
    return n;
  endfunction

  task automatic clear_sched();
    for (int i = 0; i < 2048; i++) rdy_sched[i] = 1'b0;
    tp_change_at = -1;
    tp_new       = '0;
    auto_rsp     = 1'b0;
    data_fifo.delete();
  endtask

  // Drive #1 after each rising edge, sample on the falling edge. A strobe driven
  // in cycle i is taken at the next edge, so sample i equals cnt i of that bit.
  task automatic run_cycles(input int n);
    logic last_done = 1'b0;
    logic rdy;
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
      rdy = rdy_sched[i] || (auto_rsp && last_done && (data_fifo.size() > 0));
      if (rdy && (data_fifo.size() > 0)) bit_data_in = data_fifo.pop_front();
      bit_rdy_in = rdy;
      if (i == tp_change_at) tp_cnt_in = tp_new;
      @(negedge clk_in);
      s_code[i] = bit_code_out;
      s_busy[i] = busy_out;
      s_done[i] = bit_done_out;
      s_inv[i]  = code_inv;
      last_done = bit_done_out;
    end
    bit_rdy_in = 1'b0;
  endtask

  initial begin
    logic [23:0] pat;
    int          base;
    logic [7:0]  exp_th;

    rst_n_in    = 1'b0;
    bit_rdy_in  = 1'b0;
    bit_data_in = 1'b0;
    t0h_cnt_in  = 8'd20;
    t1h_cnt_in  = 8'd40;
    tp_cnt_in   = 8'd62;
    clear_sched();
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check_val("rst_code", bit_code_out, 0);
    check_val("rst_busy", busy_out, 0);
    check_val("rst_done", bit_done_out, 0);
    check_val("rst_code_inv", code_inv, 1);
    rst_n_in = 1'b1;

    // Single '1' bit: 40 high, 22 low, 62 busy, done at cnt 61.
    clear_sched();
    data_fifo.push_back(1'b1);
    rdy_sched[0] = 1'b1;
    run_cycles(66);
    check_val("one_idle_before", s_code[0], 0);
    check_val("one_lead_high", lead_val(0, 1, 62, 1'b1), 40);
    check_val("one_total_high", count_ones(0, 0, 66), 40);
    check_val("one_busy", count_ones(1, 0, 66), 62);
    check_val("one_done_cnt", count_ones(2, 0, 66), 1);
    check_val("one_done_at61", s_done[61], 1);
    check_val("one_idle_after", s_code[63], 0);
    check_val("inv_idle_before", s_inv[0], 1);
    check_val("inv_lead_low", lead_val(3, 1, 62, 1'b0), 40);
    check_val("inv_total_high", count_ones(3, 1, 62), 22);
    check_val("inv_idle_after", s_inv[64], 1);

    // 24 gapless bits 0xA5C3F0 MSB-first, controller answers done with a registered rdy.
    clear_sched();
    pat = 24'hA5C3F0;
    for (int b = 0; b < 24; b++) begin
      data_fifo.push_back(pat[23-b]);
      exp_q.push_back(pat[23-b] ? 8'd40 : 8'd20);
    end
    auto_rsp     = 1'b1;
    rdy_sched[0] = 1'b1;
    run_cycles(24 * 62 + 4);
    for (int b = 0; b < 24; b++) begin
      base   = 1 + 62 * b;
      exp_th = exp_q.pop_front();
      check_val($sformatf("b2b_lead_%0d", b), lead_val(0, base, 62, 1'b1), int'(exp_th));
      check_val($sformatf("b2b_high_%0d", b), count_ones(0, base, 62), int'(exp_th));
    end
    check_val("b2b_busy", count_ones(1, 0, 24 * 62 + 4), 24 * 62);
    check_val("b2b_done_cnt", count_ones(2, 0, 24 * 62 + 4), 24);
    check_val("b2b_idle_after", s_code[24 * 62 + 1], 0);

    // Clamp: tp=2 -> 3, t0h=0 -> 1.
    clear_sched();
    t0h_cnt_in = 8'd0;
    tp_cnt_in  = 8'd2;
    data_fifo.push_back(1'b0);
    rdy_sched[0] = 1'b1;
    run_cycles(8);
    check_val("clmp_lead_high", lead_val(0, 1, 3, 1'b1), 1);
    check_val("clmp_total_high", count_ones(0, 0, 8), 1);
    check_val("clmp_busy", count_ones(1, 0, 8), 3);
    check_val("clmp_done_at2", s_done[2], 1);
    check_val("clmp_done_cnt", count_ones(2, 0, 8), 1);

    // Clamp: th >= tp keeps the line high for the whole period.
    clear_sched();
    t1h_cnt_in = 8'd70;
    tp_cnt_in  = 8'd62;
    data_fifo.push_back(1'b1);
    rdy_sched[0] = 1'b1;
    run_cycles(66);
    check_val("full_lead_high", lead_val(0, 1, 62, 1'b1), 62);
    check_val("full_low_after", s_code[63], 0);
    check_val("full_busy", count_ones(1, 0, 66), 62);

    // Mid-bit strobe at cnt 10 is dropped; tp change at cnt 20 only affects the next bit.
    clear_sched();
    t0h_cnt_in   = 8'd20;
    t1h_cnt_in   = 8'd40;
    data_fifo.push_back(1'b1);
    data_fifo.push_back(1'b1);
    data_fifo.push_back(1'b0);
    rdy_sched[0]  = 1'b1;
    rdy_sched[10] = 1'b1;
    rdy_sched[70] = 1'b1;
    tp_change_at  = 20;
    tp_new        = 8'd30;
    run_cycles(115);
    check_val("ign_busy1", count_ones(1, 0, 70), 62);
    check_val("ign_high1", count_ones(0, 0, 64), 40);
    check_val("ign_done1", count_ones(2, 0, 70), 1);
    check_val("ign_not_queued", count_ones(1, 63, 8), 0);
    check_val("ign_busy2", count_ones(1, 71, 44), 30);
    check_val("ign_lead2", lead_val(0, 71, 30, 1'b1), 20);
    check_val("ign_high2", count_ones(0, 64, 51), 20);

    // Reset at cnt 15 of a '1' bit, then a normal bit after release.
    clear_sched();
    tp_cnt_in = 8'd62;
    data_fifo.push_back(1'b1);
    rdy_sched[0] = 1'b1;
    run_cycles(16);
    check_val("mid_high_before", s_code[15], 1);
    rst_n_in = 1'b0;
    #1;
    check_val("mid_rst_code", bit_code_out, 0);
    check_val("mid_rst_busy", busy_out, 0);
    check_val("mid_rst_code_inv", code_inv, 1);
    @(negedge clk_in);
    check_val("mid_rst_done", bit_done_out, 0);
    check_val("mid_no_done_before", count_ones(2, 0, 16), 0);
    rst_n_in = 1'b1;
    clear_sched();
    data_fifo.push_back(1'b1);
    rdy_sched[0] = 1'b1;
    run_cycles(66);
    check_val("post_lead_high", lead_val(0, 1, 62, 1'b1), 40);
    check_val("post_busy", count_ones(1, 0, 66), 62);
    check_val("post_done_cnt", count_ones(2, 0, 66), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
